// File: rtl/bin_to_bcd.sv
// Iterative double-dabble binary-to-BCD converter for the HEX display digits.
// Define BIN_TO_BCD_SATURATE_EN to force all-nines on overflow instead of the modulo result.
module bin_to_bcd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic int unsigned max_in_range(input int d);
    int unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned   MAX_VAL  = max_in_range(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

`ifdef BIN_TO_BCD_SATURATE_EN
  function automatic logic [BCD_W-1:0] sat_digits(input logic [BCD_W-1:0] s, input logic ovf);
    return ovf ? {DIGITS{4'h9}} : s;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  bin_sr;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  adj;
  logic              ovf_cap;

  assign adj = add3(scratch);

  // Datapath: no reset needed, always loaded on accept before use
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      bin_sr  <= bin;
      scratch <= '0;
      ovf_cap <= (32'(bin) > MAX_VAL);
    end else if (state == SHIFT) begin
      scratch <= {adj[BCD_W-2:0], bin_sr[WIDTH-1]};
      bin_sr  <= bin_sr << 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          // Last iteration happens on the edge that takes the counter from 1 to 0
          if (cnt <= CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= ovf_cap;
`ifdef BIN_TO_BCD_SATURATE_EN
          bcd      <= sat_digits(scratch, ovf_cap);
`else
          bcd      <= scratch;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver queues expected results, monitor checks on done.
module tb_bin_to_bcd;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  bin = '0;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic              overflow;

  bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [15:0] last_bcd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      last_bcd = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got bcd 0x%0h with nothing pending (cycle %0d)", bcd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", bcd, e.bcd);
        check("overflow", overflow, e.ovf);
        check("latency", cyc - e.acc, WIDTH + 1);
        check("busy_at_done", busy, 0);
      end
      last_bcd = bcd;
    end else begin
      check("bcd_hold", bcd, last_bcd);
    end
  end

  task automatic issue(input logic [WIDTH-1:0] v, input logic [15:0] eb, input logic eo,
                       input bit accept);
    exp_t e;
    start = 1'b1;
    bin   = v;
    if (accept) begin
      e = '{eb, eo, cyc + 1};
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input logic [15:0] eb, input logic eo);
    issue(v, eb, eo, 1'b1);
    check("busy_after_accept", busy, 1);
    repeat (WIDTH + 3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] sat_exp;
`ifdef BIN_TO_BCD_SATURATE_EN
    sat_exp = 16'h9999;
`else
    sat_exp = 16'h6383;
`endif
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bcd", bcd, 16'h0000);
    check("reset_overflow", overflow, 0);

    convert(14'd1234, 16'h1234, 1'b0);
    convert(14'd0,    16'h0000, 1'b0);
    convert(14'd9999, 16'h9999, 1'b0);
    convert(14'd16383, sat_exp, 1'b1);
    convert(14'd10000, (sat_exp == 16'h9999) ? 16'h9999 : 16'h0000, 1'b1);
    convert(14'd507,  16'h0507, 1'b0);

    // Busy protection: extra starts at +3 and +10 must be ignored
    issue(14'd4321, 16'h4321, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    issue(14'd55, 16'h0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    issue(14'd55, 16'h0, 1'b0, 1'b0);
    repeat (WIDTH + 4) @(negedge clk);

    // Back-to-back: restart in the done cycle
    issue(14'd42, 16'h0042, 1'b0, 1'b1);
    for (int n = 0; n < 40 && !done; n++) @(negedge clk);
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL b2b_timeout: got no done within 40 cycles, required one");
    end
    issue(14'd7, 16'h0007, 1'b0, 1'b1);
    repeat (8) begin
      check("b2b_hold", bcd, 16'h0042);
      @(negedge clk);
    end
    repeat (WIDTH) @(negedge clk);

    // Reset mid-conversion
    issue(14'd1111, 16'h1111, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_bcd", bcd, 16'h0000);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    convert(14'd800, 16'h0800, 1'b0);

    check("pending_results", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
